// File: rtl/rom_arb_if.sv
// Request/response/ROM bundle for rom_port_arbiter.
// slave = arbiter side, master = requesters, response consumer and ROM model.
interface rom_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_addr, rom_data, rsp_ready,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );
  modport master (
    output req_valid, req_addr, rom_data, rsp_ready,
    input  req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous single-port ROM among NUM_REQ requesters, one read per cycle.
// Fixed priority by default; define ROM_ARB_ROUND_ROBIN_EN for round-robin.
module rom_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input logic      clk,
  input logic      rst_n,
  rom_arb_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic                               rsp_vld;
  logic [ID_WIDTH-1:0]                rsp_id_q;
  logic [ADDR_WIDTH-1:0]              held_addr;
  logic                               slot_free;
  logic                               issue;
  logic [GW-1:0]                      g;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign addr_v[i]        = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.req_ready[i] = issue && (g == GW'(i));
  end

  assign slot_free = !rsp_vld || bus.rsp_ready;
  assign issue     = slot_free && (|bus.req_valid);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last_grant;
  logic          found;
  int            j;

  // Rotating search starting one past the last winner.
  always_comb begin
    g     = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(last_grant) + 1 + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req_valid[GW'(j)]) begin
        g     = GW'(j);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= GW'(NUM_REQ - 1);
    else if (issue) last_grant <= g;
  end
`else
  always_comb begin
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[k]) g = GW'(k);
  end
`endif

  // Holding the address while stalled keeps the ROM output, and thus rsp_data, stable.
  assign bus.rom_addr = issue ? addr_v[g] : held_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_id_q  <= '0;
      held_addr <= '0;
    end else if (issue) begin
      rsp_vld   <= 1'b1;
      rsp_id_q  <= ID_WIDTH'(g);
      held_addr <= addr_v[g];
    end else if (bus.rsp_ready) begin
      rsp_vld   <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = bus.rom_data;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed and random checks of rom_port_arbiter against a mem[a]=a^A5 ROM model.
module tb_rom_port_arbiter;
  localparam int N = 4, AW = 8, DW = 8, IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_arb_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();
  rom_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always @(posedge clk) bus.rom_data <= bus.rom_addr ^ 8'hA5;

  logic [N-1:0]         rv;
  logic [N-1:0][AW-1:0] ra;
  logic                 rrdy;
  assign bus.req_valid = rv;
  assign bus.req_addr  = ra;
  assign bus.rsp_ready = rrdy;

  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] d; } exp_t;
  exp_t q[$];
  exp_t e;

  int total = 0, passed = 0;
  logic [N-1:0]         pend;
  logic [N-1:0][AW-1:0] pend_addr;
  logic [N-1:0]         gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; also enforces that unaccepted requests stay stable.
  task automatic cyc();
    #1;
    for (int i = 0; i < N; i++)
      if (pend[i]) chk($sformatf("hold_req%0d", i), {23'd0, rv[i], ra[i]}, {23'd0, 1'b1, pend_addr[i]});
    pend      = rv & ~bus.req_ready;
    pend_addr = ra;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rv = '0; ra = '0; rrdy = 1'b1; pend = '0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    rrdy = 1'b1;
    for (int n = 0; n < 40 && rv != '0; n++) begin
      #1; gnt = bus.req_ready;
      cyc();
      rv &= ~gnt;
    end
    if (rv != '0) chk("drain_timeout", 32'(rv), 32'd0);
    rv = '0;
    cyc(); cyc();
    chk("drain_idle", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_exp, prev;
    logic sf, exp_issue;
    int idx;
    rv = '0; ra = '0; rrdy = 1'b1; pend = '0;
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rom_addr",  32'(bus.rom_addr),  0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single requester 2
    ra[2] = 8'h10; rv = 4'b0100; #1;
    chk("t1_ready",    32'(bus.req_ready), 32'h4);
    chk("t1_rom_addr", 32'(bus.rom_addr),  32'h10);
    chk("t1_rsp_v0",   32'(bus.rsp_valid), 0);
    cyc(); rv = '0; #1;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id",    32'(bus.rsp_id),    2);
    chk("t1_rsp_data",  32'(bus.rsp_data),  32'hB5);
    chk("t1_idle_rdy",  32'(bus.req_ready), 0);
    chk("t1_idle_addr", 32'(bus.rom_addr),  32'h10);
    cyc(); #1;
    chk("t1_popped", 32'(bus.rsp_valid), 0);

    // all requesters continuously valid
    do_reset();
    ra[0] = 8'h01; ra[1] = 8'h02; ra[2] = 8'h03; ra[3] = 8'h04; rv = 4'hF;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      g_exp = k % N;
`else
      g_exp = 0;
`endif
      chk($sformatf("t2_grant%0d", k), 32'(bus.req_ready), 32'(1) << g_exp);
      chk($sformatf("t2_addr%0d", k),  32'(bus.rom_addr),  32'(g_exp + 1));
      if (k > 0) begin
        chk($sformatf("t2_rv%0d", k),   32'(bus.rsp_valid), 1);
        chk($sformatf("t2_id%0d", k),   32'(bus.rsp_id),    32'(prev));
        chk($sformatf("t2_data%0d", k), 32'(bus.rsp_data),  32'((prev + 1) ^ 8'hA5));
      end
      prev = g_exp;
      cyc();
    end
    drain();

    // stall with response pending
    ra[1] = 8'h20; rv = 4'b0010; rrdy = 1'b1; #1;
    chk("t4_grant", 32'(bus.req_ready), 32'h2);
    cyc();
    rv = 4'b0001; ra[0] = 8'h30; rrdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_stall_rv",   32'(bus.rsp_valid), 1);
      chk("t4_stall_id",   32'(bus.rsp_id),    1);
      chk("t4_stall_data", 32'(bus.rsp_data),  32'h85);
      chk("t4_stall_rdy",  32'(bus.req_ready), 0);
      chk("t4_stall_addr", 32'(bus.rom_addr),  32'h20);
      cyc();
    end
    rrdy = 1'b1; #1;
    chk("t4_same_cycle_grant", 32'(bus.req_ready), 32'h1);
    chk("t4_same_cycle_addr",  32'(bus.rom_addr),  32'h30);
    chk("t4_same_cycle_rv",    32'(bus.rsp_valid), 1);
    cyc(); rv = '0; #1;
    chk("t4_b2b_rv",   32'(bus.rsp_valid), 1);
    chk("t4_b2b_id",   32'(bus.rsp_id),    0);
    chk("t4_b2b_data", 32'(bus.rsp_data),  32'h95);
    cyc(); #1;
    chk("t4_popped", 32'(bus.rsp_valid), 0);

    // reset while a response is in flight
    ra[1] = 8'h40; rv = 4'b0010; rrdy = 1'b0; #1;
    chk("t5_grant", 32'(bus.req_ready), 32'h2);
    cyc(); rv = '0; #1;
    chk("t5_inflight", 32'(bus.rsp_valid), 1);
    rst_n = 1'b0; pend = '0; #1;
    chk("t5_async_rv",   32'(bus.rsp_valid), 0);
    chk("t5_async_id",   32'(bus.rsp_id),    0);
    chk("t5_async_addr", 32'(bus.rom_addr),  0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rrdy = 1'b1; #1;
    chk("t5_idle_addr", 32'(bus.rom_addr),  0);
    chk("t5_idle_rdy",  32'(bus.req_ready), 0);
    ra[0] = 8'h41; ra[1] = 8'h42; ra[2] = 8'h43; ra[3] = 8'h44; rv = 4'hF; #1;
    chk("t5_first_grant", 32'(bus.req_ready), 32'h1);
    drain();

    // random traffic against scoreboard
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      if (c < 9950) begin
        for (int i = 0; i < N; i++)
          if (!rv[i] && $urandom_range(0, 2) == 0) begin rv[i] = 1'b1; ra[i] = 8'($urandom); end
        rrdy = ($urandom_range(0, 3) != 0);
      end else begin
        rrdy = 1'b1;
      end
      #1;
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0));
      sf = (q.size() != 0) ? rrdy : 1'b1;
      exp_issue = sf && (rv != '0);
      if (bus.rsp_valid && rrdy && q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_rsp_id",   32'(bus.rsp_id),   32'(e.id));
        chk("rnd_rsp_data", 32'(bus.rsp_data), 32'(e.d));
      end
      gnt = bus.req_ready;
      chk("rnd_grant_legal",
          {29'd0, ((gnt & (gnt - 4'd1)) == '0), ((gnt & ~rv) == '0), (gnt != '0)},
          {29'd0, 1'b1, 1'b1, exp_issue});
      if (gnt != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        chk("rnd_rom_addr", 32'(bus.rom_addr), 32'(ra[idx]));
        q.push_back({IW'(idx), ra[idx] ^ 8'hA5});
      end
      cyc();
      rv &= ~gnt;
    end
    chk("rnd_all_accepted", 32'(rv), 0);
    chk("rnd_sb_empty",     32'(q.size()), 0);
    chk("rnd_final_rv",     32'(bus.rsp_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
